varredura_display: RTL and testbench

Four-digit multiplexed scan controller for seven-segment displays. It latches a packed BCD word with per-digit decimal-point flags and time-multiplexes one digit at a time onto a shared 4-bit BCD bus plus DP line, which feeds the BCD-to-seven-segment decoder directly. It also drives an active-low one-hot digit-enable (anode) bus. Value updates are frame-synchronous to avoid tearing, and optional leading-zero blanking is supported.

---
 rtl/varredura_pkg.sv | 24 ++
 rtl/gerador_tick.sv | 29 ++
 rtl/varredura_display.sv | 160 ++++++++++++++++
 tb/tb_varredura_display.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/varredura_pkg.sv
// Shared constants and helpers for the seven-segment scan controller.
// The helpers work on the widest supported display (8 digits); callers
// zero-extend their operands and truncate the results to their own width.
package varredura_pkg;

  localparam int N_DIGITOS_PAD     = 4;
  localparam int DIV_VARREDURA_PAD = 50000;
  localparam int N_DIGITOS_MAX     = 8;

  // Active-low one-hot digit enable for digit idx
  function automatic logic [N_DIGITOS_MAX-1:0] anodo_onehot(input logic [2:0] idx);
    logic [N_DIGITOS_MAX-1:0] r;
    r      = '1;
    r[idx] = 1'b0;
    return r;
  endfunction

  // Nibble i of a packed BCD word, digit 0 in the least significant nibble
  function automatic logic [3:0] digito(input logic [4*N_DIGITOS_MAX-1:0] valor,
                                        input logic [2:0] i);
    return valor[{i, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/gerador_tick.sv
// Free-running prescaler: counts 0..DIV-1 and flags the last count with a
// single-cycle tick, so a consumer advances once every DIV clocks.
module gerador_tick #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int            CW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Prescaler counter, wraps after the tick cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == CNT_MAX);

endmodule

// File: rtl/varredura_display.sv
// Four-digit (parameterisable) multiplexed seven-segment scan controller.
// Loads go to a shadow set and are promoted to the display set only at a
// frame boundary, so a frame never mixes old and new digits.
module varredura_display
  import varredura_pkg::*;
#(
  parameter int N_DIGITOS     = N_DIGITOS_PAD,
  parameter int DIV_VARREDURA = DIV_VARREDURA_PAD
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   carga,
  input  logic [4*N_DIGITOS-1:0] valor_bcd,
  input  logic [N_DIGITOS-1:0]   pontos,
  input  logic                   apaga_zeros,
  output logic [3:0]             bcd_out,
  output logic                   dp_out,
  output logic [N_DIGITOS-1:0]   anodo,
  output logic                   quadro_fim,
  output logic                   pendente
);

  localparam int            IW      = $clog2(N_DIGITOS);
  localparam logic [IW-1:0] IDX_MAX = IW'(N_DIGITOS - 1);

  logic                   tick;
  logic                   fronteira;
  logic [IW-1:0]          idx;
  logic [IW-1:0]          idx_nxt;

  logic [4*N_DIGITOS-1:0] sh_valor;
  logic [N_DIGITOS-1:0]   sh_pontos;
  logic                   sh_apaga;

  logic [4*N_DIGITOS-1:0] dv_valor;
  logic [N_DIGITOS-1:0]   dv_pontos;
  logic                   dv_apaga;

  logic [4*N_DIGITOS-1:0] dv_valor_nxt;
  logic [N_DIGITOS-1:0]   dv_pontos_nxt;
  logic                   dv_apaga_nxt;

  logic [4*N_DIGITOS_MAX-1:0] valor_ext;
  logic [N_DIGITOS-1:0]       apagado;
  logic [N_DIGITOS-1:0]       anodo_nxt;
  logic [3:0]                 bcd_nxt;
  logic                       dp_nxt;

  gerador_tick #(
    .DIV (DIV_VARREDURA)
  ) u_gerador_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  assign fronteira = tick && (idx == IDX_MAX);
  assign idx_nxt   = (idx == IDX_MAX) ? '0 : idx + IW'(1);

  // Display set as it will be after this edge: a same-cycle load wins over the shadow
  always_comb begin
    dv_valor_nxt  = dv_valor;
    dv_pontos_nxt = dv_pontos;
    dv_apaga_nxt  = dv_apaga;
    if (fronteira) begin
      if (carga) begin
        dv_valor_nxt  = valor_bcd;
        dv_pontos_nxt = pontos;
        dv_apaga_nxt  = apaga_zeros;
      end else if (pendente) begin
        dv_valor_nxt  = sh_valor;
        dv_pontos_nxt = sh_pontos;
        dv_apaga_nxt  = sh_apaga;
      end
    end
  end

  // Shadow set captures every load; pendente tracks a load not yet displayed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_valor  <= '0;
      sh_pontos <= '0;
      sh_apaga  <= 1'b0;
      pendente  <= 1'b0;
    end else begin
      if (carga) begin
        sh_valor  <= valor_bcd;
        sh_pontos <= pontos;
        sh_apaga  <= apaga_zeros;
      end
      if (carga && !fronteira) begin
        pendente <= 1'b1;
      end else if (fronteira) begin
        pendente <= 1'b0;
      end
    end
  end

  // Display set register, only changes at a frame boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dv_valor  <= '0;
      dv_pontos <= '0;
      dv_apaga  <= 1'b0;
    end else begin
      dv_valor  <= dv_valor_nxt;
      dv_pontos <= dv_pontos_nxt;
      dv_apaga  <= dv_apaga_nxt;
    end
  end

  // Widen the display word so the shared nibble helper can index it
  always_comb begin
    valor_ext                  = '0;
    valor_ext[4*N_DIGITOS-1:0] = dv_valor_nxt;
  end

  // Leading-zero chain from the top digit down; a digit or DP breaks it, digit 0 never blanks
  always_comb begin
    logic cadeia;
    cadeia  = 1'b1;
    apagado = '0;
    for (int i = N_DIGITOS - 1; i >= 0; i--) begin
      cadeia     = cadeia && (digito(valor_ext, 3'(i)) == 4'd0) && !dv_pontos_nxt[i];
      apagado[i] = dv_apaga_nxt && cadeia && (i != 0);
    end
  end

  // Drive values for the digit that becomes active on the next tick
  always_comb begin
    anodo_nxt = '1;
    bcd_nxt   = 4'd0;
    dp_nxt    = 1'b0;
    if (!apagado[idx_nxt]) begin
      anodo_nxt = N_DIGITOS'(anodo_onehot(3'(idx_nxt)));
      bcd_nxt   = digito(valor_ext, 3'(idx_nxt));
      dp_nxt    = dv_pontos_nxt[idx_nxt];
    end
  end

  // Scan position and registered display outputs, advanced once per tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= IDX_MAX;
      anodo      <= '1;
      bcd_out    <= 4'd0;
      dp_out     <= 1'b0;
      quadro_fim <= 1'b0;
    end else begin
      quadro_fim <= fronteira;
      if (tick) begin
        idx     <= idx_nxt;
        anodo   <= anodo_nxt;
        bcd_out <= bcd_nxt;
        dp_out  <= dp_nxt;
      end
    end
  end

endmodule

// File: tb/tb_varredura_display.sv
// Bench for varredura_display with 4 digits and a 4-cycle prescaler.
// Each load pushes the four hand-written per-digit expectations onto a
// scoreboard; they are popped as the digits appear on the scan outputs.
module tb_varredura_display;

  localparam int N     = 4;
  localparam int DIV   = 4;
  localparam int FRAME = N * DIV;

  logic        clk         = 1'b0;
  logic        rst_n       = 1'b0;
  logic        carga       = 1'b0;
  logic [15:0] valor_bcd   = '0;
  logic [3:0]  pontos      = '0;
  logic        apaga_zeros = 1'b0;
  logic [3:0]  bcd_out;
  logic        dp_out;
  logic [3:0]  anodo;
  logic        quadro_fim;
  logic        pendente;

  varredura_display #(
    .N_DIGITOS     (N),
    .DIV_VARREDURA (DIV)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .carga       (carga),
    .valor_bcd   (valor_bcd),
    .pontos      (pontos),
    .apaga_zeros (apaga_zeros),
    .bcd_out     (bcd_out),
    .dp_out      (dp_out),
    .anodo       (anodo),
    .quadro_fim  (quadro_fim),
    .pendente    (pendente)
  );

  always #5 clk = ~clk;

  // One load and the frame it must produce; nibble/bit d of each expectation is digit d
  typedef struct {
    logic [15:0] valor;
    logic [3:0]  pontos;
    logic        apaga;
    logic [15:0] expAnodo;
    logic [15:0] expBcd;
    logic [3:0]  expDp;
  } vec_t;

  typedef struct {
    logic [3:0] anodo;
    logic [3:0] bcd;
    logic       dp;
  } exp_t;

  vec_t vecs [11];
  exp_t sb [$];
  int   compared   = 0;
  int   mismatched = 0;
  int   edgeCnt    = 0;

  // Compare one observed value against the bench's expectation
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, required %0h (edge %0d)", name, act, req, edgeCnt);
    end
  endtask

  // Advance one clock edge, sample just after it; a load strobe lasts one edge
  task automatic stepEdge();
    @(posedge clk);
    #1;
    edgeCnt++;
    carga = 1'b0;
  endtask

  // Advance until the edge count reaches the given offset within the frame
  task automatic stepTo(input int off);
    do stepEdge(); while ((edgeCnt % FRAME) != off);
  endtask

  // Present a load; it is sampled on the next edge
  task automatic applyStimulus(input vec_t v);
    valor_bcd   = v.valor;
    pontos      = v.pontos;
    apaga_zeros = v.apaga;
    carga       = 1'b1;
  endtask

  task automatic pushFrame(input vec_t v);
    exp_t e;
    for (int d = 0; d < N; d++) begin
      e.anodo = v.expAnodo[4*d +: 4];
      e.bcd   = v.expBcd[4*d +: 4];
      e.dp    = v.expDp[d];
      sb.push_back(e);
    end
  endtask

  // Walk one whole frame from the boundary edge, checking every cycle of every digit
  task automatic checkFrame();
    exp_t cur;
    cur.anodo = 4'hF;
    cur.bcd   = 4'h0;
    cur.dp    = 1'b0;
    for (int d = 0; d < N; d++) begin
      for (int c = 0; c < DIV; c++) begin
        stepEdge();
        if (c == 0) begin
          if (sb.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL scoreboard: empty at digit %0d (edge %0d)", d, edgeCnt);
          end else begin
            cur = sb.pop_front();
          end
        end
        checkOutput($sformatf("anodo d%0d c%0d", d, c), 32'(anodo), 32'(cur.anodo));
        checkOutput($sformatf("bcd_out d%0d c%0d", d, c), 32'(bcd_out), 32'(cur.bcd));
        checkOutput($sformatf("dp_out d%0d c%0d", d, c), 32'(dp_out), 32'(cur.dp));
        if (d == 0 && c == 0) begin
          checkOutput("quadro_fim at boundary", 32'(quadro_fim), 32'd1);
          checkOutput("pendente at boundary", 32'(pendente), 32'd0);
        end
        if (d == 0 && c == 1) begin
          checkOutput("quadro_fim after boundary", 32'(quadro_fim), 32'd0);
        end
      end
    end
  endtask

  // Hard time limit so the run always ends
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: time limit reached, compared %0d", compared);
    $fatal(1, "[TB] watchdog expired");
  end

  // Main test sequence
  initial begin
    vec_t tmp;

    vecs[0]  = '{16'h1234, 4'b0000, 1'b0, 16'h7BDE, 16'h1234, 4'b0000};
    vecs[1]  = '{16'h0050, 4'b0000, 1'b1, 16'hFFDE, 16'h0050, 4'b0000};
    vecs[2]  = '{16'h0000, 4'b0000, 1'b1, 16'hFFFE, 16'h0000, 4'b0000};
    vecs[3]  = '{16'h0007, 4'b0100, 1'b1, 16'hFBDE, 16'h0007, 4'b0100};
    vecs[4]  = '{16'h0000, 4'b0000, 1'b0, 16'h7BDE, 16'h0000, 4'b0000};
    vecs[5]  = '{16'hABCF, 4'b1001, 1'b0, 16'h7BDE, 16'hABCF, 4'b1001};
    vecs[6]  = '{16'h1000, 4'b0000, 1'b1, 16'h7BDE, 16'h1000, 4'b0000};
    vecs[7]  = '{16'h0000, 4'b0001, 1'b1, 16'hFFFE, 16'h0000, 4'b0001};
    vecs[8]  = '{16'h0102, 4'b0000, 1'b1, 16'hFBDE, 16'h0102, 4'b0000};
    vecs[9]  = '{16'h9999, 4'b0000, 1'b0, 16'h7BDE, 16'h9999, 4'b0000};
    vecs[10] = '{16'h2222, 4'b0110, 1'b1, 16'h7BDE, 16'h2222, 4'b0110};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset anodo", 32'(anodo), 32'hF);
    checkOutput("reset bcd_out", 32'(bcd_out), 32'h0);
    checkOutput("reset dp_out", 32'(dp_out), 32'h0);
    checkOutput("reset pendente", 32'(pendente), 32'h0);
    checkOutput("reset quadro_fim", 32'(quadro_fim), 32'h0);
    rst_n   = 1'b1;
    edgeCnt = 0;
    stepTo(3);
    checkOutput("dark before first tick", 32'(anodo), 32'hF);

    // Table-driven frames: load mid-frame, displayed from the next boundary
    for (int k = 0; k < 9; k++) begin
      stepTo(5);
      applyStimulus(vecs[k]);
      stepEdge();
      checkOutput($sformatf("pendente after load %0d", k), 32'(pendente), 32'd1);
      pushFrame(vecs[k]);
      stepTo(3);
      checkFrame();
    end

    // Load on the boundary tick cycle goes straight to the display
    applyStimulus(vecs[0]);
    pushFrame(vecs[0]);
    checkFrame();

    // Load while digit 1 is active must not tear the current frame
    stepTo(8);
    applyStimulus(vecs[9]);
    stepEdge();
    checkOutput("pendente mid-frame", 32'(pendente), 32'd1);
    stepTo(12);
    checkOutput("old digit2 anodo", 32'(anodo), 32'hB);
    checkOutput("old digit2 bcd", 32'(bcd_out), 32'h2);
    stepTo(0);
    checkOutput("old digit3 anodo", 32'(anodo), 32'h7);
    checkOutput("old digit3 bcd", 32'(bcd_out), 32'h1);
    checkOutput("pendente before boundary", 32'(pendente), 32'd1);
    pushFrame(vecs[9]);
    stepTo(3);
    checkFrame();

    // Two loads in one frame: last write wins
    tmp = '{16'h1111, 4'b1111, 1'b0, 16'h0, 16'h0, 4'h0};
    stepTo(6);
    applyStimulus(tmp);
    stepEdge();
    stepTo(10);
    applyStimulus(vecs[10]);
    stepEdge();
    checkOutput("pendente after second load", 32'(pendente), 32'd1);
    pushFrame(vecs[10]);
    stepTo(3);
    checkFrame();

    // Asynchronous reset mid-scan discards the pending load
    tmp = '{16'h5555, 4'b1111, 1'b0, 16'h0, 16'h0, 4'h0};
    stepTo(5);
    applyStimulus(tmp);
    stepEdge();
    stepTo(12);
    checkOutput("digit2 lit before reset", 32'(anodo), 32'hB);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset anodo", 32'(anodo), 32'hF);
    checkOutput("async reset bcd_out", 32'(bcd_out), 32'h0);
    checkOutput("async reset dp_out", 32'(dp_out), 32'h0);
    checkOutput("async reset pendente", 32'(pendente), 32'h0);
    @(negedge clk);
    rst_n   = 1'b1;
    edgeCnt = 0;
    stepTo(3);
    checkOutput("dark at edge 3 after reset", 32'(anodo), 32'hF);
    stepEdge();
    checkOutput("digit0 anodo after reset", 32'(anodo), 32'hE);
    checkOutput("digit0 bcd after reset", 32'(bcd_out), 32'h0);
    checkOutput("digit0 dp after reset", 32'(dp_out), 32'h0);
    checkOutput("quadro_fim after reset", 32'(quadro_fim), 32'd1);
    checkOutput("pendente after reset", 32'(pendente), 32'd0);

    checkOutput("scoreboard drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
